// File: rtl/fe_instr_sender.sv
// fe_instr_sender: fetch-side transmitter of the FE1->decode instruction path.
// Buffers fetch packets in a small circular FIFO and forwards them to decode,
// throttled by a credit counter that mirrors free decode uop-queue slots.
// A branch mispredict flushes the buffer but leaves the credits alone.
// Optional build macro: FE_SENDER_BYPASS_EN -- lets a fill packet go straight to
// decode in the same cycle when the buffer is empty and a credit is available.
module fe_instr_sender #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int DE_CREDITS = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              fill_valid_fe0,
  input  logic [DATA_W-1:0]                 fill_instr_fe0,
  output logic                              fill_ready_fe0,
  input  logic                              de_pop_de1,
  input  logic                              br_mispred_rb1,
  output logic                              valid_fe1,
  output logic [DATA_W-1:0]                 instr_fe1,
  output logic [$clog2(DE_CREDITS+1)-1:0]   credits_fe1,
  output logic                              buf_empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int CRED_W = $clog2(DE_CREDITS+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CRED_W-1:0] r_credits;

  logic              w_empty;
  logic              w_full;
  logic              w_has_credit;
  logic              w_send_buf;
  logic              w_bypass;
  logic              w_push;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CRED_W-1:0] w_credits_nxt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_has_credit = (r_credits != '0);

  // Ready depends on occupancy only; a same-cycle send does not open a slot early.
  assign fill_ready_fe0 = reset_n & ~w_full & ~br_mispred_rb1;

  // Head-of-buffer send: needs a packet, a credit, and no flush in progress.
  assign w_send_buf = reset_n & ~w_empty & w_has_credit & ~br_mispred_rb1;

`ifdef FE_SENDER_BYPASS_EN
  // Empty buffer with a credit: the fill packet goes straight to decode.
  assign w_bypass = reset_n & w_empty & w_has_credit & ~br_mispred_rb1 & fill_valid_fe0;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push    = fill_valid_fe0 & fill_ready_fe0 & ~w_bypass;
  assign valid_fe1 = w_send_buf | w_bypass;
  assign instr_fe1 = w_send_buf ? r_mem[r_rd_ptr] :
                     (w_bypass ? fill_instr_fe0 : '0);

  assign buf_empty   = w_empty;
  assign credits_fe1 = r_credits;

  // Occupancy follows push/pop; both in one cycle leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_send_buf})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Credits: a send spends one, a decode pop returns one; clamp at both ends.
  always_comb begin
    w_credits_nxt = r_credits;
    case ({valid_fe1, de_pop_de1})
      2'b10:   if (r_credits != '0) w_credits_nxt = r_credits - CRED_W'(1);
      2'b01:   if (r_credits != CRED_W'(DE_CREDITS)) w_credits_nxt = r_credits + CRED_W'(1);
      default: w_credits_nxt = r_credits;
    endcase
  end

  // Pointer/count state; a mispredict discards every buffered packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (br_mispred_rb1) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_send_buf) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Credit register survives a mispredict; only reset restores the full count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_credits <= CRED_W'(DE_CREDITS);
    else          r_credits <= w_credits_nxt;
  end

  // Packet storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= fill_instr_fe0;
  end

  // Decode must never return a credit it was not given.
  a_no_credit_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(de_pop_de1 && (r_credits == CRED_W'(DE_CREDITS))));

  // A refused fill must be held stable until taken, unless a flush drops it.
  a_fill_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (fill_valid_fe0 && !fill_ready_fe0 && !br_mispred_rb1) |=>
    (br_mispred_rb1 || (fill_valid_fe0 && $stable(fill_instr_fe0))));

endmodule

// File: tb/tb_fe_instr_sender.sv
// Testbench for fe_instr_sender: directed vector table, hand-written reset and
// bypass sequences, then constrained-random traffic against a queue-based model.
module tb_fe_instr_sender;

  localparam int DATA_W     = 16;
  localparam int DEPTH      = 4;
  localparam int DE_CREDITS = 2;
`ifdef FE_SENDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              fill_valid_fe0;
  logic [DATA_W-1:0] fill_instr_fe0;
  logic              fill_ready_fe0;
  logic              de_pop_de1;
  logic              br_mispred_rb1;
  logic              valid_fe1;
  logic [DATA_W-1:0] instr_fe1;
  logic [1:0]        credits_fe1;
  logic              buf_empty;

  fe_instr_sender #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DE_CREDITS(DE_CREDITS)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fill_valid_fe0 (fill_valid_fe0),
    .fill_instr_fe0 (fill_instr_fe0),
    .fill_ready_fe0 (fill_ready_fe0),
    .de_pop_de1     (de_pop_de1),
    .br_mispred_rb1 (br_mispred_rb1),
    .valid_fe1      (valid_fe1),
    .instr_fe1      (instr_fe1),
    .credits_fe1    (credits_fe1),
    .buf_empty      (buf_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of buffered packets plus an integer credit count.
  logic [DATA_W-1:0] mq[$];
  int                mcred;
  logic              cur_fv, cur_pop, cur_mis;
  logic [DATA_W-1:0] cur_ins;
  logic              m_valid, m_ready, m_byp;
  logic [DATA_W-1:0] m_instr;

  typedef struct packed {
    logic              fv;
    logic [DATA_W-1:0] ins;
    logic              pop;
    logic              mis;
    logic              ev;
    logic [DATA_W-1:0] ei;
    logic              er;
    logic [1:0]        ec;
    logic              ee;
  } vec_t;

  vec_t tbl [23];

  localparam logic [DATA_W-1:0] A  = 16'hA001, B  = 16'hB002, C  = 16'hC003;
  localparam logic [DATA_W-1:0] E  = 16'hE005, X  = 16'hDEAD, D  = 16'hD00D;
  localparam logic [DATA_W-1:0] P1 = 16'h1111, P2 = 16'h2222, P3 = 16'h3333;
  localparam logic [DATA_W-1:0] P4 = 16'h4444, P5 = 16'h5555, Z  = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [DATA_W-1:0] ins, input logic pop, input logic mis);
    @(negedge clk);
    fill_valid_fe0 = fv;  fill_instr_fe0 = ins;
    de_pop_de1     = pop; br_mispred_rb1 = mis;
    cur_fv = fv; cur_ins = ins; cur_pop = pop; cur_mis = mis;
    #1;
  endtask

  task automatic model_eval();
    m_byp   = BYP && (mq.size() == 0) && (mcred > 0) && !cur_mis && cur_fv;
    m_ready = (mq.size() < DEPTH) && !cur_mis;
    m_valid = !cur_mis && (mcred > 0) && ((mq.size() > 0) || m_byp);
    if (!m_valid)          m_instr = '0;
    else if (mq.size() > 0) m_instr = mq[0];
    else                    m_instr = cur_ins;
  endtask

  task automatic cmp_model(input string tag);
    model_eval();
    chk({tag, " valid"},   32'(valid_fe1),      32'(m_valid));
    chk({tag, " instr"},   32'(instr_fe1),      32'(m_instr));
    chk({tag, " ready"},   32'(fill_ready_fe0), 32'(m_ready));
    chk({tag, " credits"}, 32'(credits_fe1),    32'(mcred));
    chk({tag, " empty"},   32'(buf_empty),      32'(mq.size() == 0));
  endtask

  task automatic tick();
    model_eval();
    if (cur_mis) mq.delete();
    else begin
      if (m_valid && !m_byp) void'(mq.pop_front());
      if (cur_fv && m_ready && !m_byp) mq.push_back(cur_ins);
    end
    mcred = mcred - (m_valid ? 1 : 0) + (cur_pop ? 1 : 0);
    if (mcred < 0) mcred = 0;
    if (mcred > DE_CREDITS) mcred = DE_CREDITS;
    @(posedge clk);
  endtask

  task automatic step(input logic fv, input logic [DATA_W-1:0] ins, input logic pop,
                      input logic mis, input string tag);
    drive(fv, ins, pop, mis);
    cmp_model(tag);
    tick();
  endtask

  initial begin
    logic              pend;
    logic              pfv;
    logic [DATA_W-1:0] pins;
    logic              ppop, pmis;

    reset_n = 1'b0;
    fill_valid_fe0 = 1'b0; fill_instr_fe0 = '0; de_pop_de1 = 1'b0; br_mispred_rb1 = 1'b0;
    mcred = DE_CREDITS;

    // fv, ins, pop, mis | valid, instr, ready, credits, empty
    tbl[0]  = '{1'b1, A,  1'b0, 1'b0, BYP,   BYP ? A : Z, 1'b1, 2'd2,              1'b1};
    tbl[1]  = '{1'b1, B,  1'b0, 1'b0, 1'b1,  BYP ? B : A, 1'b1, BYP ? 2'd1 : 2'd2, BYP};
    tbl[2]  = '{1'b1, C,  1'b0, 1'b0, !BYP,  BYP ? Z : B, 1'b1, BYP ? 2'd0 : 2'd1, BYP};
    tbl[3]  = '{1'b0, Z,  1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, Z,  1'b1, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, Z,  1'b0, 1'b0, 1'b1,  C,  1'b1, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, Z,  1'b1, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b1};
    tbl[7]  = '{1'b0, Z,  1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, E,  1'b0, 1'b0, BYP,   BYP ? E : Z, 1'b1, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, Z,  1'b0, 1'b0, !BYP,  BYP ? Z : E, 1'b1, BYP ? 2'd0 : 2'd1, BYP};
    tbl[10] = '{1'b1, P1, 1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b1};
    tbl[11] = '{1'b1, P2, 1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[12] = '{1'b1, P3, 1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[13] = '{1'b1, P4, 1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[14] = '{1'b0, Z,  1'b0, 1'b0, 1'b0,  Z,  1'b0, 2'd0, 1'b0};
    tbl[15] = '{1'b0, Z,  1'b1, 1'b0, 1'b0,  Z,  1'b0, 2'd0, 1'b0};
    tbl[16] = '{1'b0, Z,  1'b0, 1'b0, 1'b1,  P1, 1'b0, 2'd1, 1'b0};
    tbl[17] = '{1'b0, Z,  1'b1, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[18] = '{1'b0, Z,  1'b0, 1'b0, 1'b1,  P2, 1'b1, 2'd1, 1'b0};
    tbl[19] = '{1'b0, Z,  1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[20] = '{1'b1, P5, 1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd0, 1'b0};
    tbl[21] = '{1'b1, X,  1'b1, 1'b1, 1'b0,  Z,  1'b0, 2'd0, 1'b0};
    tbl[22] = '{1'b0, Z,  1'b0, 1'b0, 1'b0,  Z,  1'b1, 2'd1, 1'b1};

    // Reset state while reset_n is held low.
    repeat (2) @(negedge clk);
    #1;
    chk("reset valid",   32'(valid_fe1),      32'd0);
    chk("reset instr",   32'(instr_fe1),      32'd0);
    chk("reset ready",   32'(fill_ready_fe0), 32'd0);
    chk("reset credits", 32'(credits_fe1),    32'(DE_CREDITS));
    chk("reset empty",   32'(buf_empty),      32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: in-order send, credit stall, full buffer, mispredict flush.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].fv, tbl[i].ins, tbl[i].pop, tbl[i].mis);
      chk($sformatf("row%0d valid", i),   32'(valid_fe1),      32'(tbl[i].ev));
      chk($sformatf("row%0d instr", i),   32'(instr_fe1),      32'(tbl[i].ei));
      chk($sformatf("row%0d ready", i),   32'(fill_ready_fe0), 32'(tbl[i].er));
      chk($sformatf("row%0d credits", i), 32'(credits_fe1),    32'(tbl[i].ec));
      chk($sformatf("row%0d empty", i),   32'(buf_empty),      32'(tbl[i].ee));
      tick();
    end

    // Reset mid-burst: two packets buffered, no credits left.
    step(1'b1, 16'h0A0A, 1'b0, 1'b0, "rst_pre0");
    step(1'b0, Z,        1'b0, 1'b0, "rst_pre1");
    step(1'b1, 16'h0B0B, 1'b0, 1'b0, "rst_pre2");
    step(1'b1, 16'h0C0C, 1'b0, 1'b0, "rst_pre3");
    @(negedge clk);
    fill_valid_fe0 = 1'b0; de_pop_de1 = 1'b0; br_mispred_rb1 = 1'b0;
    chk("midrst pre credits", 32'(credits_fe1), 32'd0);
    chk("midrst pre empty",   32'(buf_empty),   32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst valid",   32'(valid_fe1),      32'd0);
    chk("midrst instr",   32'(instr_fe1),      32'd0);
    chk("midrst ready",   32'(fill_ready_fe0), 32'd0);
    chk("midrst credits", 32'(credits_fe1),    32'(DE_CREDITS));
    chk("midrst empty",   32'(buf_empty),      32'd1);
    mq.delete();
    mcred = DE_CREDITS;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("postrst credits", 32'(credits_fe1),    32'(DE_CREDITS));
    chk("postrst ready",   32'(fill_ready_fe0), 32'd1);

    // Empty buffer, full credits: D appears now with bypass, one cycle later without.
    drive(1'b1, D, 1'b0, 1'b0);
    chk("lat c0 valid", 32'(valid_fe1), 32'(BYP));
    chk("lat c0 instr", 32'(instr_fe1), BYP ? 32'(D) : 32'd0);
    tick();
    drive(1'b0, Z, 1'b0, 1'b0);
    chk("lat c1 valid", 32'(valid_fe1), 32'(!BYP));
    chk("lat c1 instr", 32'(instr_fe1), BYP ? 32'd0 : 32'(D));
    tick();

    // Random traffic obeying the interface rules.
    pend = 1'b0; pins = '0;
    for (int c = 0; c < 600; c++) begin
      if (pend) pfv = 1'b1;
      else begin
        pfv  = ($urandom_range(0, 2) != 0);
        pins = DATA_W'($urandom);
      end
      ppop = (mcred < DE_CREDITS) && ($urandom_range(0, 2) == 0);
      pmis = ($urandom_range(0, 24) == 0);
      drive(pfv, pins, ppop, pmis);
      cmp_model($sformatf("rnd%0d", c));
      pend = pfv && !m_ready && !pmis;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
